lif_neuron_42in: RTL and testbench

//  Leaky integrate-and-fire neuron. Consumes the 42-synapse sum from adder_42in and integrates it into a

---
 rtl/lif_neuron_42in_pkg.sv | 15 +
 rtl/snn_sat_add.sv | 18 +
 rtl/lif_neuron_42in.sv | 89 ++++++++
 tb/tb_lif_neuron_42in.sv | 126 ++++++++++++
 4 files changed

// File: rtl/lif_neuron_42in_pkg.sv
// rtl/lif_neuron_42in_pkg.sv - shared tinySNN neuron definitions
// State encodings and default widths used by the neuron and its helpers.
package lif_neuron_42in_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRAC    = 2'd2
  } lif_state_e;

  localparam int                  DEF_MEM_WIDTH = 24;
  localparam logic [23:0]         DEF_THRESHOLD = 24'h001000;
  localparam int                  SPIKE_CNT_W   = 16;

endpackage

// File: rtl/snn_sat_add.sv
// rtl/snn_sat_add.sv - unsigned adder saturating at all-ones
// Shared with the synapse weight path; one guard bit detects overflow.
module snn_sat_add #(
  parameter int p_width = 24
) (
  input  logic [p_width-1:0] a_i,
  input  logic [p_width-1:0] b_i,
  output logic [p_width-1:0] s_o
);

  logic [p_width:0] sum_wide;

  always_comb begin
    sum_wide = {1'b0, a_i} + {1'b0, b_i};
    s_o      = sum_wide[p_width] ? {p_width{1'b1}} : sum_wide[p_width-1:0];
  end

endmodule

// File: rtl/lif_neuron_42in.sv
// rtl/lif_neuron_42in.sv - leaky integrate-and-fire neuron for one adder_42in sum
// Integrates with shift leak, fires a one-cycle spike, then sits out a refractory window.
module lif_neuron_42in
  import lif_neuron_42in_pkg::*;
#(
  parameter int                     p_input_width = 16,
  parameter int                     p_mem_width   = DEF_MEM_WIDTH,
  parameter logic [p_mem_width-1:0] p_threshold   = p_mem_width'(DEF_THRESHOLD),
  parameter int                     p_leak_shift  = 4,
  parameter int                     p_refrac      = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [p_input_width+5:0]   i_sum,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_spike,
  output logic [p_mem_width-1:0]     o_mem,
  output logic [SPIKE_CNT_W-1:0]     o_spike_cnt
);

  localparam int RW = (p_refrac > 1) ? $clog2(p_refrac + 1) : 1;

  lif_state_e                 state_q;
  logic [p_mem_width-1:0]     mem_q;
  logic [p_mem_width-1:0]     mem_d;
  logic [p_mem_width-1:0]     decayed;
  logic [p_mem_width-1:0]     sum_ext;
  logic                       spike_q;
  logic [SPIKE_CNT_W-1:0]     cnt_q;
  logic [RW-1:0]              refr_q;

  // Leak never exceeds mem_q, so the subtraction cannot underflow.
  always_comb begin
    decayed = mem_q - (mem_q >> p_leak_shift);
    sum_ext = p_mem_width'(i_sum);
  end

  snn_sat_add #(.p_width(p_mem_width)) u_sat_add (
    .a_i (decayed),
    .b_i (sum_ext),
    .s_o (mem_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INTEGRATE;
      mem_q   <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      refr_q  <= '0;
    end else begin
      spike_q <= 1'b0;
      case (state_q)
        ST_INTEGRATE: begin
          if (i_valid) begin
            if (mem_d >= p_threshold) begin
              mem_q   <= '0;
              spike_q <= 1'b1;
              cnt_q   <= cnt_q + SPIKE_CNT_W'(1);
              state_q <= ST_FIRE;
            end else begin
              mem_q <= mem_d;
            end
          end
        end
        ST_FIRE: begin
          if (p_refrac > 0) begin
            refr_q  <= RW'(p_refrac);
            state_q <= ST_REFRAC;
          end else begin
            state_q <= ST_INTEGRATE;
          end
        end
        ST_REFRAC: begin
          refr_q <= refr_q - RW'(1);
          if (refr_q == RW'(1)) state_q <= ST_INTEGRATE;
        end
        default: state_q <= ST_INTEGRATE;
      endcase
    end
  end

  assign o_ready     = (state_q == ST_INTEGRATE);
  assign o_spike     = spike_q;
  assign o_mem       = mem_q;
  assign o_spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_neuron_42in.sv
// tb/tb_lif_neuron_42in.sv - directed vector bench for lif_neuron_42in
// Default neuron plus a saturation-configured instance sharing clock and reset.
module tb_lif_neuron_42in;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] sum, sum2;
  logic        valid, valid2;
  logic        ready, ready2, spike, spike2;
  logic [23:0] mem, mem2;
  logic [15:0] cnt, cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_neuron_42in dut (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_valid(valid),
    .o_ready(ready), .o_spike(spike), .o_mem(mem), .o_spike_cnt(cnt)
  );

  lif_neuron_42in #(.p_threshold(24'hFFFFFF), .p_refrac(0)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_sum(sum2), .i_valid(valid2),
    .o_ready(ready2), .o_spike(spike2), .o_mem(mem2), .o_spike_cnt(cnt2)
  );

  typedef struct {
    logic        valid;
    logic [21:0] sum;
    logic [23:0] mem;
    logic        spike;
    logic        ready;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];
  logic [23:0] sat_exp[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [23:0] prev;
    // valid, sum, expected mem, spike, ready, spike count
    vecs[0]  = '{1'b1, 22'h000100, 24'h000100, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 22'h000000, 24'h0000F0, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 22'h000000, 24'h0000E1, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 22'h000000, 24'h0000E1, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 22'h000F2D, 24'h000000, 1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 22'h002000, 24'h000000, 1'b0, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 22'h002000, 24'h000000, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 22'h002000, 24'h000000, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 22'h002000, 24'h000000, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b1, 22'h000FFF, 24'h000FFF, 1'b0, 1'b1, 16'd1};
    vecs[10] = '{1'b1, 22'h000010, 24'h000F10, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b1, 22'h001000, 24'h000000, 1'b1, 1'b0, 16'd2};
    vecs[12] = '{1'b0, 22'h000000, 24'h000000, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 22'h000000, 24'h000000, 1'b0, 1'b0, 16'd2};

    sat_exp[0] = 24'h3FFFFF;
    sat_exp[1] = 24'h7BFFFF;
    sat_exp[2] = 24'hB43FFF;
    sat_exp[3] = 24'hE8FBFF;
    sat_exp[4] = 24'h000000;

    rst = 1'b1; valid = 1'b0; valid2 = 1'b0; sum = '0; sum2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem",   32'(mem),   32'h0);
    check("reset_spike", 32'(spike), 32'h0);
    check("reset_ready", 32'(ready), 32'h1);
    check("reset_cnt",   32'(cnt),   32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      valid = vecs[i].valid;
      sum   = vecs[i].sum;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_mem", i),   32'(mem),   32'(vecs[i].mem));
      check($sformatf("row%0d_spike", i), 32'(spike), 32'(vecs[i].spike));
      check($sformatf("row%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
      check($sformatf("row%0d_cnt", i),   32'(cnt),   32'(vecs[i].cnt));
    end

    // Refractory counter is now 2: reset must win.
    rst = 1'b1; valid = 1'b1; sum = 22'h002000;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(ready), 32'h1);
    check("midrst_mem",   32'(mem),   32'h0);
    check("midrst_cnt",   32'(cnt),   32'h0);
    check("midrst_spike", 32'(spike), 32'h0);
    rst = 1'b0; valid = 1'b0; sum = '0;

    valid2 = 1'b1; sum2 = 22'h3FFFFF; prev = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_mem", k),   32'(mem2),   32'(sat_exp[k]));
      check($sformatf("sat%0d_spike", k), 32'(spike2), (k == 4) ? 32'h1 : 32'h0);
      if (k < 4) begin
        check($sformatf("sat%0d_monotonic", k), 32'(mem2 > prev), 32'h1);
        prev = mem2;
      end
    end
    check("sat_fire_ready", 32'(ready2), 32'h0);
    check("sat_fire_cnt",   32'(cnt2),   32'h1);
    valid2 = 1'b0;
    @(posedge clk);
    #1;
    check("sat_after_ready", 32'(ready2), 32'h1);
    check("sat_after_spike", 32'(spike2), 32'h0);
    check("sat_after_mem",   32'(mem2),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
